// File: rtl/rwmem_pkg.sv
// rwmem_pkg
// Shared definitions for the rwmem2p simple-dual-port RAM.
// - state_t      : clear-sequencer states (sweep vs normal service)
// - RWMEM_DATA_W : default word width
// - RWMEM_ADDR_W : default address width
package rwmem_pkg;

  localparam int RWMEM_DATA_W = 8;
  localparam int RWMEM_ADDR_W = 4;

  // ST_CLEAR is the reset state so that every reset starts a fresh sweep
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

endpackage

// File: rtl/rwmem2p_array.sv
// rwmem2p_array
// Plain storage array: one synchronous write port, one combinational read
// port. Contents are never reset; the parent's clear sweep defines them.
// Ports:
//   clk    in   write clock, rising edge
//   wen    in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], unregistered
module rwmem2p_array
  import rwmem_pkg::*;
#(
  parameter int DATA_W = RWMEM_DATA_W,
  parameter int ADDR_W = RWMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset on the array so it maps onto plain RAM cells
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rwmem2p.sv
// rwmem2p
// Parametrised simple-dual-port synchronous RAM with a built-in clear
// sequencer. After reset (or a clr request in IDLE) every location is
// swept to CLR_VAL, one address per cycle, while busy is high. In IDLE
// one write and one registered read can be serviced per cycle; a read of
// the address being written in the same cycle returns the new data.
// Ports:
//   clk     in   single clock, rising edge
//   rst     in   asynchronous active-high reset
//   clr     in   clear request, sampled in IDLE
//   busy    out  high while a clear sweep runs (user ports ignored)
//   we      in   write enable
//   waddr   in   write address
//   din     in   write data
//   re      in   read enable
//   raddr   in   read address
//   dout    out  registered read data
//   rvalid  out  one-cycle strobe, dout updated by a read
module rwmem2p
  import rwmem_pkg::*;
#(
  parameter int                 DATA_W  = RWMEM_DATA_W,
  parameter int                 ADDR_W  = RWMEM_ADDR_W,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout,
  output logic              rvalid
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_last;

  logic              arr_wen;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              rd_fire;
  logic              bypass;

  // Last sweep address is all-ones, i.e. DEPTH-1
  assign cnt_last = (cnt == {ADDR_W{1'b1}});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_CLEAR: if (cnt_last) next_state = ST_IDLE;
      ST_IDLE:  if (clr)      next_state = ST_CLEAR;
      default:                next_state = ST_CLEAR;
    endcase
  end

  // Output logic: the sweep owns the write port while clearing,
  // otherwise the user write port passes straight through
  always_comb begin
    busy      = 1'b1;
    arr_wen   = 1'b1;
    arr_waddr = cnt;
    arr_wdata = CLR_VAL;
    rd_fire   = 1'b0;
    if (state == ST_IDLE) begin
      busy      = 1'b0;
      arr_wen   = we;
      arr_waddr = waddr;
      arr_wdata = din;
      rd_fire   = re;
    end
  end

  // Sweep counter only moves while clearing; it wraps to 0 on the last
  // address, so it is already at 0 when the next sweep begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_CLEAR) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Write-first: a same-cycle write to the read address wins over the
  // array's old contents
  assign bypass = we && (waddr == raddr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_fire;
      if (rd_fire) begin
        dout <= bypass ? din : arr_rdata;
      end
    end
  end

  rwmem2p_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .wen   (arr_wen),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (raddr),
    .rdata (arr_rdata)
  );

endmodule
